tick_period_meter: RTL and testbench
====================================

Name: tick_period_meter

Overview:
Receive-side companion to the modulo-k rollover counter. Samples a single-cycle tick stream (e.g. a rollover pulse) and measures the number of clock cycles between consecutive ticks. Reports each measured period with a one-cycle valid strobe, flags overflow, and indicates lock when two consecutive periods match. Used to check or recover a programmed divide ratio on the same clock domain.

Parameters:
N, 4, width of period counter and o_period; measurable range 1..2^N-1; N >= 2

Ports:
i_clk  input  1  system clock, rising-edge
i_reset  input  1  reset, asynchronous, active-high
i_tick  input  1  event pulse; sampled each rising edge; each high sample is one tick
i_clear  input  1  synchronous clear; returns block to idle
o_period  output  N  last measured period in clock cycles (saturated)
o_valid  output  1  one-cycle strobe: o_period/o_overflow/o_locked updated this cycle
o_overflow  output  1  last period reached saturation (2^N-1) before the tick arrived
o_locked  output  1  last two consecutive periods equal and neither overflowed

Behaviour:
- Reset (async, i_reset=1): state S_IDLE, cnt=0, prev=0, o_period=0, o_valid=0, o_overflow=0, o_locked=0. Outputs held while i_reset high.
- States: S_IDLE (waiting for first tick), S_ARMED (first period running, no previous period), S_TRACK (at least one period captured).
- S_IDLE: tick sampled -> cnt<=1, go S_ARMED. No tick -> stay; outputs unchanged.
- S_ARMED/S_TRACK, no tick: cnt<=cnt+1, saturating at 2^N-1; sat flag set when cnt reaches 2^N-1.
- S_ARMED/S_TRACK, tick sampled at edge E: o_period<=cnt, o_overflow<=sat, o_valid<=1 for exactly the cycle after E; cnt<=1, sat<=0; go/stay S_TRACK.
- Period definition: ticks sampled at edges E0 and E0+P -> o_period=P. Tick high every cycle -> P=1 each cycle, o_valid held high.
- o_locked on capture: 1 iff state was S_TRACK, cnt==prev, sat==0, and previous capture not overflowed; else 0. prev<=cnt on every capture. Capture out of S_ARMED always gives o_locked=0.
- o_valid is 0 in every cycle not directly following a capture. o_period/o_overflow/o_locked hold between captures.
- Overflow: cnt stays at 2^N-1 until a tick arrives. That capture reports o_period=2^N-1, o_overflow=1, o_locked=0. No timeout back to idle.
- i_clear=1 (sync): same values as reset at next edge. Overrides a simultaneous tick; that tick is discarded.
- Reset mid-period: period in progress is lost; the next tick counts as the first tick again.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Package tick_period_meter_pkg: typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRACK} state_t; no other shared constants.
- One sub-module sat_counter #(N): sync load-to-1, saturating increment, exposes count and sat flag. The FSM and capture registers stay in tick_period_meter.

Test Plan:
1. Reset for 3 time units, then tick every 4 cycles, N=4 -> first o_valid after 2nd tick with o_period=4, o_locked=0; from 3rd tick on o_period=4, o_locked=1, o_overflow=0.
2. Tick held high continuously -> o_valid high every cycle from the 2nd tick, o_period=1, o_locked=1 from the 3rd tick.
3. N=3, ticks 10 cycles apart -> o_period=7, o_overflow=1, o_locked=0 on every capture.
4. Periods 4,4,5,5 -> o_locked sequence 1,0,1 on the captures after the first capture.
5. i_clear asserted on the same edge as a tick in S_TRACK -> all outputs 0, no o_valid. Next two ticks 3 apart -> o_period=3, o_locked=0.
6. Assert i_reset asynchronously between edges mid-period -> outputs 0 immediately. After release, ticks 6 apart -> first capture o_period=6.

Source files
------------

// File: rtl/tick_period_meter_pkg.sv
// tick_period_meter_pkg
//   Shared types for the tick period meter.
//   state_t : S_IDLE  - waiting for the first tick
//             S_ARMED - first period running, nothing captured yet
//             S_TRACK - at least one period captured
package tick_period_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRACK = 2'd2
  } state_t;

endpackage

// File: rtl/tick_period_meter_if.sv
// tick_period_meter_if
//   Groups the tick/clear inputs and measurement outputs of tick_period_meter.
//   master : stimulus side (drives i_tick, i_clear; observes results)
//   slave  : meter side    (samples i_tick, i_clear; drives results)
//   i_tick     - event pulse, one tick per high sample
//   i_clear    - synchronous clear back to idle
//   o_period   - last measured period (saturated at 2^N-1)
//   o_valid    - one-cycle strobe, results updated this cycle
//   o_overflow - last period saturated before its closing tick
//   o_locked   - last two periods equal and neither overflowed
interface tick_period_meter_if #(parameter int N = 4);
  logic         i_tick;
  logic         i_clear;
  logic [N-1:0] o_period;
  logic         o_valid;
  logic         o_overflow;
  logic         o_locked;

  modport master (
    output i_tick, i_clear,
    input  o_period, o_valid, o_overflow, o_locked
  );

  modport slave (
    input  i_tick, i_clear,
    output o_period, o_valid, o_overflow, o_locked
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
//   N-bit up counter with synchronous load-to-1 and saturation at 2^N-1.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (cnt=0, sat=0)
//   clr  - synchronous clear to 0 (wins over load/inc)
//   load - synchronous load of 1, clears sat (wins over inc)
//   inc  - increment enable; holds once saturated
//   cnt  - current count
//   sat  - high while cnt sits at 2^N-1
module sat_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [N-1:0] cnt,
  output logic         sat
);

  localparam logic [N-1:0] MAX = '1;
  localparam logic [N-1:0] ONE = N'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (load) begin
      cnt <= ONE;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      cnt <= cnt + ONE;
      // Flag goes up together with the count reaching the top value.
      if (cnt == MAX - ONE) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter
//   Measures the number of clock cycles between consecutive sampled ticks.
//   Each capture updates period/overflow/locked and pulses valid for one cycle.
//   i_clk   - system clock, rising edge
//   i_reset - asynchronous active-high reset
//   bus     - slave modport: i_tick, i_clear in; o_period, o_valid,
//             o_overflow, o_locked out (all registered)
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  tick_period_meter_if.slave   bus
);

  state_t       state, state_nxt;
  logic [N-1:0] cnt;
  logic         sat;
  logic         cnt_load, cnt_inc, capture, lock_nxt;

  logic [N-1:0] period_q, prev_q;
  logic         valid_q, ovf_q, locked_q;

  sat_counter #(.N(N)) u_cnt (
    .clk  (i_clk),
    .rst  (i_reset),
    .clr  (bus.i_clear),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .sat  (sat)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Clear discards any tick sampled on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    if (bus.i_clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_tick) begin
            cnt_load  = 1'b1;
            state_nxt = S_ARMED;
          end
        end
        S_ARMED, S_TRACK: begin
          if (bus.i_tick) begin
            capture   = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = S_TRACK;
          end else begin
            cnt_inc   = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Lock needs a prior captured period; ovf_q still holds the previous
  // capture's overflow flag at this point.
  assign lock_nxt = (state == S_TRACK) && (cnt == prev_q) && !sat && !ovf_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      period_q <= '0;
      prev_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      locked_q <= 1'b0;
    end else if (bus.i_clear) begin
      period_q <= '0;
      prev_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        period_q <= cnt;
        prev_q   <= cnt;
        ovf_q    <= sat;
        locked_q <= lock_nxt;
      end
    end
  end

  assign bus.o_period   = period_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_locked   = locked_q;

endmodule

// File: tb/tb_tick_period_meter.sv
module tb_tick_period_meter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tick_period_meter_if #(.N(4)) bus4 ();
  tick_period_meter_if #(.N(3)) bus3 ();

  tick_period_meter #(.N(4)) dut4 (.i_clk(clk), .i_reset(rst), .bus(bus4));
  tick_period_meter #(.N(3)) dut3 (.i_clk(clk), .i_reset(rst), .bus(bus3));

  typedef struct {
    int period;
    int ovf;
    int locked;
    int due;
  } exp_t;

  typedef struct {
    int dut;
    int gap;
    bit has;
    int period;
    int ovf;
    int locked;
  } vec_t;

  exp_t q4[$];
  exp_t q3[$];
  vec_t vecs[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tick(input int d, input logic v);
    if (d == 0) bus4.i_tick = v;
    else        bus3.i_tick = v;
  endtask

  // Drive one tick `gap` cycles after the previous one; when `has` is set
  // the capture on that tick's edge is expected with the given results.
  task automatic send_tick(input int d, input int gap, input bit has,
                           input int p, input int o, input int l);
    exp_t e;
    for (int i = 1; i < gap; i++) begin
      set_tick(d, 1'b0);
      cyc();
    end
    set_tick(d, 1'b1);
    if (has) begin
      e.period = p; e.ovf = o; e.locked = l; e.due = cyc_cnt + 1;
      if (d == 0) q4.push_back(e);
      else        q3.push_back(e);
    end
    cyc();
    set_tick(d, 1'b0);
  endtask

  task automatic mon(input int d, input logic v, input int p, input int o, input int l);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q4.size() > 0) : (q3.size() > 0);
    if (have) e = (d == 0) ? q4[0] : q3[0];
    if (v) begin
      if (!have || e.due != cyc_cnt) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid dut%0d: got valid=1, required valid=0 (cycle %0d)", d, cyc_cnt);
      end else begin
        if (d == 0) void'(q4.pop_front());
        else        void'(q3.pop_front());
        check($sformatf("period dut%0d", d), p, e.period);
        check($sformatf("overflow dut%0d", d), o, e.ovf);
        check($sformatf("locked dut%0d", d), l, e.locked);
      end
    end else if (have && e.due <= cyc_cnt) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_valid dut%0d: got valid=0, required valid=1 (cycle %0d)", d, cyc_cnt);
      if (d == 0) void'(q4.pop_front());
      else        void'(q3.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus4.o_valid, int'(bus4.o_period), int'(bus4.o_overflow), int'(bus4.o_locked));
    mon(1, bus3.o_valid, int'(bus3.o_period), int'(bus3.o_overflow), int'(bus3.o_locked));
  end

  task automatic check_zero4(input string tag);
    check({tag, " period"},   int'(bus4.o_period), 0);
    check({tag, " valid"},    int'(bus4.o_valid), 0);
    check({tag, " overflow"}, int'(bus4.o_overflow), 0);
    check({tag, " locked"},   int'(bus4.o_locked), 0);
  endtask

  task automatic add(input int d, input int g, input bit h, input int p, input int o, input int l);
    vec_t v;
    v.dut = d; v.gap = g; v.has = h; v.period = p; v.ovf = o; v.locked = l;
    vecs.push_back(v);
  endtask

  initial begin
    // N=4: steady period 4, then 4,4,5,5, then continuous ticks, then overflow
    add(0, 1, 0, 0, 0, 0);
    add(0, 4, 1, 4, 0, 0);
    add(0, 4, 1, 4, 0, 1);
    add(0, 4, 1, 4, 0, 1);
    add(0, 4, 1, 4, 0, 1);
    add(0, 5, 1, 5, 0, 0);
    add(0, 5, 1, 5, 0, 1);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1);
    add(0, 1, 1, 1, 0, 1);
    add(0, 20, 1, 15, 1, 0);
    add(0, 3, 1, 3, 0, 0);
    add(0, 3, 1, 3, 0, 1);
    // N=3: saturating periods, then recovery
    add(1, 1, 0, 0, 0, 0);
    add(1, 10, 1, 7, 1, 0);
    add(1, 10, 1, 7, 1, 0);
    add(1, 10, 1, 7, 1, 0);
    add(1, 2, 1, 2, 0, 0);
    add(1, 2, 1, 2, 0, 1);

    rst = 1'b1;
    bus4.i_tick = 1'b0; bus4.i_clear = 1'b0;
    bus3.i_tick = 1'b0; bus3.i_clear = 1'b0;
    #2;
    check_zero4("reset4");
    check("reset3 period", int'(bus3.o_period), 0);
    check("reset3 valid",  int'(bus3.o_valid), 0);
    #1;
    rst = 1'b0;
    cyc();
    cyc();

    foreach (vecs[i])
      send_tick(vecs[i].dut, vecs[i].gap, vecs[i].has,
                vecs[i].period, vecs[i].ovf, vecs[i].locked);

    // Clear on the same edge as a tick while tracking
    cyc();
    cyc();
    bus4.i_tick  = 1'b1;
    bus4.i_clear = 1'b1;
    cyc();
    bus4.i_tick  = 1'b0;
    bus4.i_clear = 1'b0;
    check_zero4("clear");
    send_tick(0, 2, 0, 0, 0, 0);
    send_tick(0, 3, 1, 3, 0, 0);
    send_tick(0, 3, 1, 3, 0, 1);

    // Asynchronous reset between edges, mid-period
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check_zero4("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    send_tick(0, 1, 0, 0, 0, 0);
    send_tick(0, 6, 1, 6, 0, 0);
    send_tick(0, 6, 1, 6, 0, 1);

    repeat (4) cyc();
    check("q4_drained", q4.size(), 0);
    check("q3_drained", q3.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
